uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART. Consumes the filtered, already-synchronised serial line from the rx input filter and sequences it through start, data, optional parity and stop bits using a bit-period counter. Delivers bytes to the host side over a valid/ready handshake. Reports framing, parity and overrun errors. Sits between the rx filter and the rx FIFO or register interface.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal range 8..65535
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rxd_filtered  in  1  filtered serial line, idle high, synchronous to clk
rx_ready  in  1  consumer accepts rx_data when high with rx_valid
rx_data  out  8  received byte, LSB = first data bit; unused MSBs = 0
rx_valid  out  1  rx_data holds an unconsumed byte
rx_perr  out  1  parity error qualifier for the current rx_data; valid while rx_valid=1
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun_err  out  1  one-cycle pulse: a completed byte was dropped because rx_valid was still high
busy  out  1  high in every state except IDLE and WAIT_IDLE

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert handled upstream): state=WAIT_IDLE. All outputs 0, bit counter 0, shift register 0.
- Bit counter: 16 bits, counts 0..CLKS_PER_BIT-1. Mid-bit point = CLKS_PER_BIT/2, integer floor.
- WAIT_IDLE: stay until rxd_filtered=1 for one cycle, then go to IDLE. This prevents a line held low from reset or from a break being read as a start bit.
- IDLE: rxd_filtered=0 -> START, counter cleared.
- START: at the mid-bit point, sample the line.
  - 0 -> DATA, counter cleared, bit index 0.
  - 1 -> IDLE. This is a glitch reject: no output activity.
- DATA: sample at counter = CLKS_PER_BIT-1, measured from the mid-start point, so every sample falls at mid-bit. Shift right into the shift register. After DATA_BITS samples -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: one sample. perr = XOR(data bits, parity bit) XOR PARITY_ODD... specifically, even parity requires XOR of all = 0, odd parity requires XOR of all = 1.
- STOP: one sample.
  - Sample 1 and rx_valid=0 (or rx_valid=1 with rx_ready=1 in the same cycle): load rx_data and rx_perr, and rx_valid goes 1 on the next clk. -> IDLE.
  - Sample 1, rx_valid=1 and rx_ready=0: drop the new byte, keep the old rx_data, pulse overrun_err. -> IDLE.
  - Sample 0: pulse frame_err, drop the byte, leave rx_valid untouched. -> WAIT_IDLE.
- Returning to IDLE at mid-stop lets a back-to-back start edge be detected with half a bit of margin.
- Handshake: rx_valid stays high until a cycle where rx_valid=1 and rx_ready=1; it clears on the next clk. rx_data and rx_perr stay stable while rx_valid=1.
- Simultaneous accept and new load in one cycle: the new byte wins. rx_valid stays 1, rx_data updates, no overrun.
- Latency: rx_valid rises 1 clk after the mid-stop sample. That is about (1.5 + DATA_BITS + PARITY_EN) × CLKS_PER_BIT + 2 clk after the start edge reaches rxd_filtered.
- Reset mid-frame: immediate abort. The partial byte is discarded, no error pulse, and the FSM returns to WAIT_IDLE.
- Width rules: the shift register is DATA_BITS wide, and rx_data zero-extends it to 8. No arithmetic overflow path; the counter never exceeds CLKS_PER_BIT-1.

Test Plan:
(All directed tests use CLKS_PER_BIT=16, DATA_BITS=8 unless stated.)
- Frame 0x55, 8N1, rx_ready=1 -> rx_valid high 1 cycle, rx_data=0x55, rx_perr=0, no error pulses, busy low after the mid-stop sample.
- Start pulse low for 5 clk then high -> no rx_valid, no error pulses, FSM back in IDLE; a following valid 0xA3 frame is received correctly.
- Frame 0x3C with stop bit forced 0 and line held low for 40 clk -> frame_err pulses once, rx_valid stays 0, no new start until the line returns high; the next 0x81 frame is received.
- Two back-to-back frames 0x12, 0x34 with rx_ready=0 -> rx_data=0x12 held, overrun_err pulses at the second stop sample. Raising rx_ready then reads 0x12 and rx_valid clears.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> rx_valid with rx_perr=1. Resend with parity bit 1 -> rx_perr=0.
- Assert rst low during DATA bit 4 of a 0xFF frame -> all outputs 0 immediately, FSM in WAIT_IDLE, no rx_valid; the next 0x5A frame after reset release is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: samples a filtered serial line at mid-bit, assembles
// start/data/parity/stop framing and hands bytes out over a valid/ready handshake.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_filtered,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_perr,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] MID_CNT  = 16'(CLKS_PER_BIT / 2);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);
    localparam logic        ODD_BIT  = (PARITY_ODD != 0);
    localparam logic        PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_reg;
    logic [15:0]            cnt_reg;
    logic [2:0]             idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   data_reg;
    logic                   perr_reg;
    logic                   rx_perr_reg;
    logic                   valid_reg;
    logic                   ferr_reg;
    logic                   ovr_reg;
    logic                   busy_reg;

    logic                   bit_done;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   par_calc;

    assign bit_done   = (cnt_reg == LAST_CNT);
    assign shift_next = {rxd_filtered, shift_reg[DATA_BITS-1:1]};
    // Nonzero when the data plus parity bit violate the configured parity sense.
    assign par_calc   = (^shift_reg) ^ rxd_filtered ^ ODD_BIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= WAIT_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            perr_reg    <= 1'b0;
            rx_perr_reg <= 1'b0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;
            if (valid_reg && rx_ready) begin
                valid_reg <= 1'b0;
            end
            case (state_reg)
                WAIT_IDLE: begin
                    if (rxd_filtered) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rxd_filtered) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_reg == MID_CNT) begin
                        cnt_reg <= '0;
                        idx_reg <= '0;
                        if (!rxd_filtered) begin
                            state_reg <= DATA;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_reg   <= '0;
                        shift_reg <= shift_next;
                        idx_reg   <= idx_reg + 3'd1;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= PAR_ON ? PARITY : STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        cnt_reg   <= '0;
                        perr_reg  <= par_calc;
                        state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_reg  <= '0;
                        busy_reg <= 1'b0;
                        if (rxd_filtered) begin
                            // Leave at mid-stop so a back-to-back start edge is still caught.
                            state_reg <= IDLE;
                            if (!valid_reg || rx_ready) begin
                                valid_reg   <= 1'b1;
                                data_reg    <= shift_reg;
                                rx_perr_reg <= PAR_ON & perr_reg;
                            end else begin
                                ovr_reg <= 1'b1;
                            end
                        end else begin
                            state_reg <= WAIT_IDLE;
                            ferr_reg  <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= WAIT_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_data
            if (gi < DATA_BITS) begin : g_used
                assign rx_data[gi] = data_reg[gi];
            end else begin : g_pad
                assign rx_data[gi] = 1'b0;
            end
        end
    endgenerate

    assign rx_valid    = valid_reg;
    assign rx_perr     = rx_perr_reg;
    assign frame_err   = ferr_reg;
    assign overrun_err = ovr_reg;
    assign busy        = busy_reg;

endmodule
